// File: rtl/intt_addsub_half_pkg.sv
// rtl/intt_addsub_half_pkg.sv - modulus, residue width and tag defaults shared by the modular arithmetic blocks
package intt_addsub_half_pkg;

    localparam int DATA_W = 30;
    localparam logic [DATA_W-1:0] Q_DEFAULT = 30'd12289;
    localparam int TAG_W_DEFAULT = 10;

    typedef logic [DATA_W-1:0] residue_t;

endpackage

// File: rtl/intt_addsub_half_mod_halve.sv
// rtl/intt_addsub_half_mod_halve.sv - combinational x * 2^-1 mod Q for odd Q and x < Q
module mod_halve
    import intt_addsub_half_pkg::*;
#(
    parameter logic [DATA_W-1:0] Q = Q_DEFAULT
) (
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W:0] even_w;

    // Adding the odd modulus to an odd value makes it even without changing its residue.
    always_comb begin
        even_w = {1'b0, x} + (x[0] ? {1'b0, Q} : {(DATA_W + 1){1'b0}});
        y      = even_w[DATA_W:1];
    end

endmodule

// File: rtl/intt_addsub_half.sv
// rtl/intt_addsub_half.sv - three-stage Gentleman-Sande add/sub with optional halving of the sum
module intt_addsub_half
    import intt_addsub_half_pkg::*;
#(
    parameter logic [DATA_W-1:0] Q     = Q_DEFAULT,
    parameter int                TAG_W = TAG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_half,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_u,
    output logic [DATA_W-1:0] out_v,
    output logic [TAG_W-1:0]  out_tag
);

    logic              valid1_q, valid1_d;
    logic [DATA_W:0]   sum1_q, sum1_d;
    logic [DATA_W-1:0] diff1_q, diff1_d;
    logic              borrow1_q, borrow1_d;
    logic              half1_q, half1_d;
    logic [TAG_W-1:0]  tag1_q, tag1_d;

    logic              valid2_q, valid2_d;
    logic [DATA_W-1:0] s2_q, s2_d;
    logic [DATA_W-1:0] d2_q, d2_d;
    logic              half2_q, half2_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;

    logic              valid3_q, valid3_d;
    logic [DATA_W-1:0] u3_q, u3_d;
    logic [DATA_W-1:0] v3_q, v3_d;
    logic [TAG_W-1:0]  tag3_q, tag3_d;

    logic              stall_w;
    logic              enable_w;
    logic [DATA_W:0]   sum_red_w;
    logic [DATA_W-1:0] halved_w;

    // A single global enable: bubbles are never squeezed out, so in_ready only sees out_ready.
    assign stall_w  = valid3_q && !out_ready;
    assign enable_w = !stall_w;
    assign in_ready = rst_n && enable_w;

    assign sum_red_w = sum1_q - {1'b0, Q};

    mod_halve #(.Q(Q)) u_mod_halve (
        .x (s2_q),
        .y (halved_w)
    );

    always_comb begin
        valid1_d  = valid1_q;
        sum1_d    = sum1_q;
        diff1_d   = diff1_q;
        borrow1_d = borrow1_q;
        half1_d   = half1_q;
        tag1_d    = tag1_q;
        valid2_d  = valid2_q;
        s2_d      = s2_q;
        d2_d      = d2_q;
        half2_d   = half2_q;
        tag2_d    = tag2_q;
        valid3_d  = valid3_q;
        u3_d      = u3_q;
        v3_d      = v3_q;
        tag3_d    = tag3_q;
        if (enable_w) begin
            valid1_d  = in_valid;
            sum1_d    = {1'b0, in_a} + {1'b0, in_b};
            diff1_d   = in_a - in_b;
            borrow1_d = in_a < in_b;
            half1_d   = in_half;
            tag1_d    = in_tag;

            valid2_d  = valid1_q;
            s2_d      = (sum1_q >= {1'b0, Q}) ? sum_red_w[DATA_W-1:0] : sum1_q[DATA_W-1:0];
            // The wrapped difference plus Q lands back in range when a < b.
            d2_d      = borrow1_q ? diff1_q + Q : diff1_q;
            half2_d   = half1_q;
            tag2_d    = tag1_q;

            valid3_d  = valid2_q;
            u3_d      = half2_q ? halved_w : s2_q;
            v3_d      = d2_q;
            tag3_d    = tag2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q  <= 1'b0;
            sum1_q    <= '0;
            diff1_q   <= '0;
            borrow1_q <= 1'b0;
            half1_q   <= 1'b0;
            tag1_q    <= '0;
            valid2_q  <= 1'b0;
            s2_q      <= '0;
            d2_q      <= '0;
            half2_q   <= 1'b0;
            tag2_q    <= '0;
            valid3_q  <= 1'b0;
            u3_q      <= '0;
            v3_q      <= '0;
            tag3_q    <= '0;
        end else begin
            valid1_q  <= valid1_d;
            sum1_q    <= sum1_d;
            diff1_q   <= diff1_d;
            borrow1_q <= borrow1_d;
            half1_q   <= half1_d;
            tag1_q    <= tag1_d;
            valid2_q  <= valid2_d;
            s2_q      <= s2_d;
            d2_q      <= d2_d;
            half2_q   <= half2_d;
            tag2_q    <= tag2_d;
            valid3_q  <= valid3_d;
            u3_q      <= u3_d;
            v3_q      <= v3_d;
            tag3_q    <= tag3_d;
        end
    end

    assign out_valid = valid3_q;
    assign out_u     = u3_q;
    assign out_v     = v3_q;
    assign out_tag   = tag3_q;

endmodule

// File: tb/tb_intt_addsub_half.sv
// tb/tb_intt_addsub_half.sv - directed and randomised checks of intt_addsub_half at Q=12289 and Q=17
module tb_intt_addsub_half;

    localparam logic [29:0] QA = 30'd12289;
    localparam logic [29:0] QB = 30'd17;

    typedef struct packed {
        logic [29:0] u;
        logic [29:0] v;
        logic [9:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [29:0] in_a      [2];
    logic [29:0] in_b      [2];
    logic        in_half   [2];
    logic [9:0]  in_tag    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [29:0] out_u     [2];
    logic [29:0] out_v     [2];
    logic [9:0]  out_tag   [2];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   recv0    = 0;

    always #5 clk = ~clk;

    intt_addsub_half #(.Q(QA), .TAG_W(10)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_half(in_half[0]), .in_tag(in_tag[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_u(out_u[0]), .out_v(out_v[0]), .out_tag(out_tag[0])
    );

    intt_addsub_half #(.Q(QB), .TAG_W(10)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_half(in_half[1]), .in_tag(in_tag[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_u(out_u[1]), .out_v(out_v[1]), .out_tag(out_tag[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [29:0] qm, input logic [29:0] a, input logic [29:0] b,
                                   input logic h, input logic [9:0] t);
        longint q  = qm;
        longint la = a;
        longint lb = b;
        longint s;
        longint u;
        longint v;
        exp_t   e;
        s = (la + lb) % q;
        u = h ? (s * ((q + 1) / 2)) % q : s;
        v = (la - lb + q) % q;
        e.u   = u[29:0];
        e.v   = v[29:0];
        e.tag = t;
        return e;
    endfunction

    task automatic cyc(input int d, input logic v, input logic [29:0] a, input logic [29:0] b,
                       input logic h, input logic [9:0] t, input logic ordy, output logic fired);
        exp_t e;
        int   qsz;
        @(negedge clk);
        in_valid[d]  = v;
        in_a[d]      = a;
        in_b[d]      = b;
        in_half[d]   = h;
        in_tag[d]    = t;
        out_ready[d] = ordy;
        #1;
        qsz = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (out_valid[d]) begin
            if (qsz == 0) begin
                check("unexpected_out", {63'd0, out_valid[d]}, 64'd0);
            end else begin
                e = (d == 0) ? exp_q0[0] : exp_q1[0];
                check("out_u", {34'd0, out_u[d]}, {34'd0, e.u});
                check("out_v", {34'd0, out_v[d]}, {34'd0, e.v});
                check("out_tag", {54'd0, out_tag[d]}, {54'd0, e.tag});
                if (ordy) begin
                    if (d == 0) begin
                        void'(exp_q0.pop_front());
                        recv0++;
                    end else begin
                        void'(exp_q1.pop_front());
                    end
                end
            end
            if (!ordy) check("in_ready_stall", {63'd0, in_ready[d]}, 64'd0);
        end else begin
            check("in_ready_free", {63'd0, in_ready[d]}, 64'd1);
        end
        fired = v && in_ready[d];
        if (fired) begin
            if (d == 0) exp_q0.push_back(model(QA, a, b, h, t));
            else        exp_q1.push_back(model(QB, a, b, h, t));
        end
    endtask

    task automatic directed(input logic [29:0] a, input logic [29:0] b, input logic h,
                            input logic [29:0] eu, input logic [29:0] ev, input logic [9:0] t);
        logic f;
        cyc(0, 1'b1, a, b, h, t, 1'b1, f);
        check("dir_accept", {63'd0, f}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b0, 30'd0, 30'd0, 1'b0, 10'd0, 1'b1, f);
            check("dir_latency", {63'd0, out_valid[0]}, (i == 2) ? 64'd1 : 64'd0);
            if (i == 2) begin
                check("dir_u", {34'd0, out_u[0]}, {34'd0, eu});
                check("dir_v", {34'd0, out_v[0]}, {34'd0, ev});
            end
        end
    endtask

    task automatic drain(input int d);
        logic f;
        for (int i = 0; i < 30; i++) begin
            if (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0)
                cyc(d, 1'b0, 30'd0, 30'd0, 1'b0, 10'd0, 1'b1, f);
        end
        check("drain_empty", (d == 0) ? 64'(exp_q0.size()) : 64'(exp_q1.size()), 64'd0);
    endtask

    initial begin
        logic f;
        int   sent;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_a[d] = '0; in_b[d] = '0; in_half[d] = 1'b0;
            in_tag[d] = '0; out_ready[d] = 1'b1;
        end
        rst_n = 1'b0;
        #12;
        check("rst_out_valid", {63'd0, out_valid[0]}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready[0]}, 64'd0);
        check("rst_out_u", {34'd0, out_u[0]}, 64'd0);
        check("rst_out_v", {34'd0, out_v[0]}, 64'd0);
        check("rst_out_tag", {54'd0, out_tag[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready[0]}, 64'd1);

        directed(30'd3,     30'd5,     1'b1, 30'd4,     30'd12287, 10'd1);
        directed(30'd0,     30'd1,     1'b1, 30'd6145,  30'd12288, 10'd2);
        directed(30'd12288, 30'd12288, 1'b1, 30'd12288, 30'd0,     10'd3);
        directed(30'd12288, 30'd1,     1'b0, 30'd0,     30'd12287, 10'd4);

        recv0 = 0;
        sent  = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0, sent < 8, 30'(sent * 1531 + 7), 30'(sent * 977 + 100), sent[0], 10'(sent),
                !(i >= 4 && i < 8), f);
            if (f) sent++;
        end
        drain(0);
        check("bp_count", 64'(recv0), 64'd8);

        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 30'(i + 10), 30'(i), 1'b0, 10'(i + 20), 1'b1, f);
        cyc(0, 1'b0, 30'd0, 30'd0, 1'b0, 10'd0, 1'b0, f);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid[0]}, 64'd0);
        check("async_rst_in_ready", {63'd0, in_ready[0]}, 64'd0);
        exp_q0.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc(0, 1'b0, 30'd0, 30'd0, 1'b0, 10'd0, 1'b1, f);

        for (int i = 0; i < 2000; i++)
            cyc(0, 1'($urandom_range(1)), 30'($urandom_range(int'(QA) - 1)),
                30'($urandom_range(int'(QA) - 1)), 1'($urandom_range(1)),
                10'($urandom_range(1023)), $urandom_range(9) < 7, f);
        drain(0);
        for (int i = 0; i < 2000; i++)
            cyc(1, 1'($urandom_range(1)), 30'($urandom_range(int'(QB) - 1)),
                30'($urandom_range(int'(QB) - 1)), 1'($urandom_range(1)),
                10'($urandom_range(1023)), $urandom_range(9) < 7, f);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
